misc_device: RTL and testbench



---
 rtl/misc_device_pkg.sv | 39 +++
 rtl/misc_timer.sv | 40 ++++
 rtl/misc_device.sv | 99 +++++++++
 tb/tb_misc_device.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/misc_device_pkg.sv
// rtl/misc_device_pkg.sv - shared widths, register offsets, state enum and info struct for misc_device
package misc_device_pkg;

  localparam int MISC_ADDR_WIDTH = 12;
  localparam int MISC_DATA_WIDTH = 64;
  localparam int MISC_MASK_WIDTH = MISC_DATA_WIDTH / 8;

  localparam logic [MISC_ADDR_WIDTH-1:0] MTIME_OFFSET    = 12'h000;
  localparam logic [MISC_ADDR_WIDTH-1:0] MTIMECMP_OFFSET = 12'h008;
  localparam logic [MISC_ADDR_WIDTH-1:0] DISPLAY_OFFSET  = 12'h010;

  localparam int TICK_DIV_DEFAULT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } misc_state_e;

  typedef struct packed {
    logic [MISC_DATA_WIDTH-1:0] mtime;
    logic [MISC_DATA_WIDTH-1:0] mtimecmp;
    logic [MISC_DATA_WIDTH-1:0] display;
  } misc_info_t;

  // Byte-lane merge shared by every writable register.
  function automatic logic [MISC_DATA_WIDTH-1:0] apply_wmask(
    input logic [MISC_DATA_WIDTH-1:0] old_val,
    input logic [MISC_DATA_WIDTH-1:0] wdata,
    input logic [MISC_MASK_WIDTH-1:0] wmask
  );
    logic [MISC_DATA_WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < MISC_MASK_WIDTH; i++) begin
      if (wmask[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/misc_timer.sv
// rtl/misc_timer.sv - mtime counter with prescaler, byte-masked write port and compare output
module misc_timer
  import misc_device_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wen,
  input  logic [MISC_DATA_WIDTH-1:0] wdata,
  input  logic [MISC_MASK_WIDTH-1:0] wmask,
  input  logic [MISC_DATA_WIDTH-1:0] mtimecmp,
  output logic [MISC_DATA_WIDTH-1:0] mtime,
  output logic                       irq
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] prescale;

  // A software write wins over the tick and restarts the prescale period.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mtime    <= '0;
      prescale <= '0;
    end else if (wen) begin
      mtime    <= apply_wmask(mtime, wdata, wmask);
      prescale <= '0;
    end else if (prescale == PRE_MAX) begin
      mtime    <= mtime + 64'd1;
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign irq = (mtime >= mtimecmp);

endmodule

// File: rtl/misc_device.sv
// rtl/misc_device.sv - MMIO misc device: request FSM, decode, mtimecmp/display registers, response register
module misc_device
  import misc_device_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wen,
  input  logic [MISC_ADDR_WIDTH-1:0] req_addr,
  input  logic [MISC_DATA_WIDTH-1:0] req_wdata,
  input  logic [MISC_MASK_WIDTH-1:0] req_wmask,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [MISC_DATA_WIDTH-1:0] resp_rdata,
  output logic                       timer_irq,
  output misc_info_t                 misc_info
);

  misc_state_e state, next_state;

  logic [MISC_DATA_WIDTH-1:0] mtime;
  logic [MISC_DATA_WIDTH-1:0] mtimecmp;
  logic [MISC_DATA_WIDTH-1:0] display;
  logic [MISC_DATA_WIDTH-1:0] rd_data;

  logic [MISC_ADDR_WIDTH-4:0] word;
  logic                       sel_mtime, sel_cmp, sel_disp;
  logic                       accept;
  logic                       unused_addr_bits;

  assign word      = req_addr[MISC_ADDR_WIDTH-1:3];
  assign sel_mtime = (word == MTIME_OFFSET[MISC_ADDR_WIDTH-1:3]);
  assign sel_cmp   = (word == MTIMECMP_OFFSET[MISC_ADDR_WIDTH-1:3]);
  assign sel_disp  = (word == DISPLAY_OFFSET[MISC_ADDR_WIDTH-1:3]);
  assign accept    = req_valid && req_ready;

  assign unused_addr_bits = ^req_addr[2:0];

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Unmapped offsets read as zero.
  always_comb begin
    rd_data = '0;
    if (sel_mtime)     rd_data = mtime;
    else if (sel_cmp)  rd_data = mtimecmp;
    else if (sel_disp) rd_data = display;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mtimecmp   <= '1;
      display    <= '0;
      resp_rdata <= '0;
    end else if (accept) begin
      resp_rdata <= req_wen ? '0 : rd_data;
      if (req_wen && sel_cmp)  mtimecmp <= apply_wmask(mtimecmp, req_wdata, req_wmask);
      if (req_wen && sel_disp) display  <= apply_wmask(display, req_wdata, req_wmask);
    end
  end

  misc_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .wen      (accept && req_wen && sel_mtime),
    .wdata    (req_wdata),
    .wmask    (req_wmask),
    .mtimecmp (mtimecmp),
    .mtime    (mtime),
    .irq      (timer_irq)
  );

  assign misc_info = '{mtime: mtime, mtimecmp: mtimecmp, display: display};

endmodule

// File: tb/tb_misc_device.sv
// tb/tb_misc_device.sv - randomized self-checking bench for misc_device at TICK_DIV 1 and 4
module tb_misc_device;
  import misc_device_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_wen;
  logic [11:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_ready;

  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [63:0] resp_rdata [2];
  logic        timer_irq  [2];
  misc_info_t  info       [2];

  always #5 clk = ~clk;

  misc_device #(.TICK_DIV(1)) dut0 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[0]),
    .timer_irq(timer_irq[0]), .misc_info(info[0])
  );

  misc_device #(.TICK_DIV(4)) dut1 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[1]),
    .timer_irq(timer_irq[1]), .misc_info(info[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference: mtime = value at last write/reset + elapsed cycles / divider.
  longint      cyc = 0;
  logic [63:0] base_val [2];
  longint      base_cyc [2];
  int          div      [2] = '{1, 4};
  logic [63:0] m_cmp;
  logic [63:0] m_disp;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_mtime(input int d);
    return base_val[d] + 64'((cyc - base_cyc[d]) / longint'(div[d]));
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] wd, input logic [7:0] m);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_read(input int d, input logic [11:0] a);
    logic [8:0] w;
    w = a[11:3];
    if (w == 9'd0) return m_mtime(d);
    if (w == 9'd1) return m_cmp;
    if (w == 9'd2) return m_disp;
    return 64'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      base_val[d] = 64'd0;
      base_cyc[d] = cyc;
    end
    m_cmp  = '1;
    m_disp = 64'd0;
  endtask

  task automatic check_state();
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("mtime%0d", d), info[d].mtime, m_mtime(d));
      check_val($sformatf("mtimecmp%0d", d), info[d].mtimecmp, m_cmp);
      check_val($sformatf("display%0d", d), info[d].display, m_disp);
      check_val($sformatf("irq%0d", d), 64'(timer_irq[d]), 64'(m_mtime(d) >= m_cmp));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_state();
    end
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("rst_resp_valid%0d", d), 64'(resp_valid[d]), 64'd0);
      check_val($sformatf("rst_req_ready%0d", d), 64'(req_ready[d]), 64'd1);
      check_val($sformatf("rst_rdata%0d", d), resp_rdata[d], 64'd0);
    end
    rstn = 1'b1;
    check_state();
  endtask

  // One request; hold>0 stalls the response and offers a competing write meanwhile.
  task automatic txn(input logic wen, input logic [11:0] addr, input logic [63:0] wd,
                     input logic [7:0] mask, input int hold, output logic [63:0] got0);
    logic [63:0] exp_rd [2];
    logic [63:0] pre    [2];
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("req_ready_idle%0d", d), 64'(req_ready[d]), 64'd1);
      exp_rd[d] = wen ? 64'd0 : m_read(d, addr);
      pre[d]    = m_mtime(d);
    end
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wd;
    req_wmask = mask;
    step();
    req_valid = 1'b0;
    if (wen) begin
      if (addr[11:3] == 9'd0) begin
        for (int d = 0; d < 2; d++) begin
          base_val[d] = merge(pre[d], wd, mask);
          base_cyc[d] = cyc;
        end
      end else if (addr[11:3] == 9'd1) begin
        m_cmp = merge(m_cmp, wd, mask);
      end else if (addr[11:3] == 9'd2) begin
        m_disp = merge(m_disp, wd, mask);
      end
    end
    check_state();
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("resp_valid%0d", d), 64'(resp_valid[d]), 64'd1);
      check_val($sformatf("resp_rdata%0d", d), resp_rdata[d], exp_rd[d]);
    end
    got0 = resp_rdata[0];
    resp_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_wen   = 1'b1;
      req_addr  = DISPLAY_OFFSET;
      req_wdata = {$urandom, $urandom};
      req_wmask = 8'hFF;
      step();
      check_state();
      for (int d = 0; d < 2; d++) begin
        check_val($sformatf("bp_resp_valid%0d", d), 64'(resp_valid[d]), 64'd1);
        check_val($sformatf("bp_req_ready%0d", d), 64'(req_ready[d]), 64'd0);
        check_val($sformatf("bp_rdata%0d", d), resp_rdata[d], exp_rd[d]);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    check_state();
    for (int d = 0; d < 2; d++)
      check_val($sformatf("resp_done%0d", d), 64'(resp_valid[d]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] r;
    logic [11:0] addr_tbl [5];
    addr_tbl = '{12'h000, 12'h008, 12'h010, 12'h018, 12'h000};
    rstn = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b1;
    step();
    do_reset();

    idle(10);
    check_val("mtime_after_10", info[0].mtime, 64'd10);
    txn(1'b0, MTIMECMP_OFFSET, 64'd0, 8'h00, 0, r);
    check_val("mtimecmp_reset_read", r, 64'hFFFF_FFFF_FFFF_FFFF);

    txn(1'b1, MTIMECMP_OFFSET, 64'd20, 8'hFF, 0, r);
    idle(12);
    check_val("irq_high_at_20", 64'(timer_irq[0]), 64'd1);

    txn(1'b1, DISPLAY_OFFSET, 64'h1122334455667788, 8'hFF, 0, r);
    txn(1'b1, DISPLAY_OFFSET, 64'hAAAA_AAAA_AAAA_AAAA, 8'h01, 0, r);
    txn(1'b0, DISPLAY_OFFSET, 64'd0, 8'h00, 0, r);
    check_val("display_merge", r, 64'h11223344556677AA);

    txn(1'b1, MTIME_OFFSET, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, r);
    idle(2);
    check_val("mtime_wrap", info[0].mtime, 64'd1);

    txn(1'b0, MTIME_OFFSET, 64'd0, 8'h00, 5, r);
    txn(1'b0, 12'h018, 64'd0, 8'h00, 0, r);
    check_val("unmapped_read", r, 64'd0);
    txn(1'b1, 12'h018, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, r);

    idle(2);
    txn(1'b1, MTIME_OFFSET, 64'd0, 8'hFF, 0, r);
    idle(2);
    check_val("div4_hold", info[1].mtime, 64'd0);
    idle(1);
    check_val("div4_tick", info[1].mtime, 64'd1);

    for (int n = 0; n < 150; n++) begin
      logic [11:0] a;
      idle($urandom_range(0, 3));
      a = addr_tbl[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) a = 12'($urandom);
      a[2:0] = 3'($urandom);
      txn(1'($urandom), a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), r);
    end

    req_valid = 1'b1; req_wen = 1'b0; req_addr = MTIME_OFFSET;
    step();
    req_valid = 1'b0;
    check_val("pre_rst_resp_valid", 64'(resp_valid[0]), 64'd1);
    rstn = 1'b0;
    step();
    model_reset();
    rstn = 1'b1;
    for (int d = 0; d < 2; d++)
      check_val($sformatf("rst_in_resp%0d", d), 64'(resp_valid[d]), 64'd0);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
